arbiter_nm: RTL

Parametrised N-master round-robin arbiter for the AXI interconnect, the successor to the fixed two-master arbiter. It selects one requesting master per address channel, holds that grant for the whole transaction, and releases it only on the final handshake of a burst. The arbiter sits in front of each address-channel mux, with one instance per AR/AW channel. An optional watchdog forcibly releases a grant that stalls.

---
 rtl/arb_pkg.sv | 22 ++
 rtl/rr_prio_pick.sv | 41 ++++
 rtl/arbiter_nm.sv | 115 +++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-master round-robin address-channel arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_M = 16;
    localparam int ARB_IDX_W = $clog2(ARB_MAX_M);

    // All-zero input maps to index 0, which is also the idle grant index.
    function automatic logic [ARB_IDX_W-1:0] onehot2idx(input logic [ARB_MAX_M-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_M; i++) begin
            if (oh[i]) idx = idx | ARB_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: rotate req so ptr sits at bit 0, take the
// lowest set bit, then rotate the one-hot result back. Zero latency.
module rr_prio_pick #(
    parameter int NUM_M = 4,
    parameter int IDX_W = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NUM_M-1:0] pick
);

    logic [NUM_M-1:0] w_rot;
    logic [NUM_M-1:0] w_enc;

    function automatic int rot_idx(input int j, input logic [IDX_W-1:0] p);
        int s;
        s = j + int'(p);
        return (s >= NUM_M) ? s - NUM_M : s;
    endfunction

    always_comb begin
        logic found;
        w_rot = '0;
        w_enc = '0;
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_M; j++) begin
            w_rot[j] = req[rot_idx(j, ptr)];
        end
        for (int j = 0; j < NUM_M; j++) begin
            if (!found && w_rot[j]) begin
                w_enc[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_M; j++) begin
            if (w_enc[j]) pick[rot_idx(j, ptr)] = 1'b1;
        end
    end

endmodule

// File: rtl/arbiter_nm.sv
// N-master round-robin arbiter holding a grant for a whole AXI transaction.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
module arbiter_nm
    import arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int IDX_W   = $clog2(NUM_M),
    parameter int TIMEOUT = 256
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [NUM_M-1:0] VALID_NM,
    input  logic             HandShake,
    input  logic             LAST,
    output logic [NUM_M-1:0] grant_out,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout_err
);

    if (NUM_M < 2 || NUM_M > ARB_MAX_M) begin : g_bad_num_m
        $error("arbiter_nm: NUM_M must be 2..16");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("arbiter_nm: TIMEOUT must be at least 2");
    end

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [NUM_M-1:0] r_lock_grant;
    logic [NUM_M-1:0] w_pick;
    logic [NUM_M-1:0] w_grant;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic             w_fin;
    logic             w_timeout;

    assign w_fin = HandShake & LAST;

    rr_prio_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (VALID_NM),
        .ptr  (r_ptr),
        .pick (w_pick)
    );

    assign w_win_idx = IDX_W'(onehot2idx(ARB_MAX_M'(w_pick)));
    assign w_ptr_nxt = (w_win_idx == IDX_W'(NUM_M - 1)) ? '0 : w_win_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = '0;
        case (r_state)
            IDLE: begin
                w_grant = w_pick;
                // A single-beat transaction finishing in its grant cycle never locks.
                if (|VALID_NM && !w_fin) w_state_nxt = LOCKED;
            end
            LOCKED: begin
                w_grant = r_lock_grant;
                if (w_fin || w_timeout) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (ARESET) w_grant = '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_lock_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && |VALID_NM) begin
                r_ptr        <= w_ptr_nxt;
                r_lock_grant <= w_pick;
            end
        end
    end

    assign grant_out = w_grant;
    assign grant_idx = IDX_W'(onehot2idx(ARB_MAX_M'(w_grant)));
    assign busy      = (r_state == LOCKED);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;

    assign w_timeout = (r_state == LOCKED) && !w_fin && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Counter idles at zero, so lock entry always starts a fresh window.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == IDLE || HandShake || w_timeout) r_cnt <= '0;
            else                                            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
